// File: rtl/cpa_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : cpa_pipe
//  Purpose  : Pipelined carry-propagate adder. The WIDTH-bit ripple is cut
//             into STAGES equal segments; each register stage resolves one
//             segment and forwards its carry plus the unresolved operand bits.
//             valid/ready stream handshake with full backpressure and
//             per-stage bubble collapsing.
//  Options  : CPA_PIPE_SUB_EN adds in_sub (A + ~B + 1, out_cout = no borrow).
//  Revision : 1.0  initial release
// ============================================================================
module cpa_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef CPA_PIPE_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
);

    localparam int SEG = WIDTH / STAGES;

    if ((WIDTH < 2) || (STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_bad_param
        $error("cpa_pipe: illegal WIDTH/STAGES combination");
    end

    // Segment ripple: returns {carry_out, sum[SEG-1:0]}.
    function automatic logic [SEG:0] f_seg(input logic [SEG-1:0] a,
                                           input logic [SEG-1:0] b,
                                           input logic           ci);
        logic [SEG-1:0] p;
        logic [SEG-1:0] g;
        logic [SEG-1:0] s;
        logic           c;
        p = a ^ b;
        g = a & b;
        c = ci;
        s = '0;
        for (int i = 0; i < SEG; i++) begin
            s[i] = p[i] ^ c;
            c    = g[i] | (p[i] & c);
        end
        return {c, s};
    endfunction

    // Stage-0 entry operands; subtraction inverts B and forces the carry-in.
    logic [WIDTH-1:0] w_b0;
    logic             w_c0;
`ifdef CPA_PIPE_SUB_EN
    assign w_b0 = in_sub ? ~in_b : in_b;
    assign w_c0 = in_sub ? 1'b1  : in_cin;
`else
    assign w_b0 = in_b;
    assign w_c0 = in_cin;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int OPW = WIDTH - k * SEG;   // operand bits still unresolved on entry

        logic                 r_v;
        logic                 r_c;
        logic [(k+1)*SEG-1:0] r_sum;
        logic [OPW-1:0]       w_opa;
        logic [OPW-1:0]       w_opb;
        logic                 w_vi;
        logic                 w_ci;
        logic                 w_adv;
        logic [SEG:0]         w_res;
        logic [(k+1)*SEG-1:0] w_sum_nx;

        if (k == 0) begin : g_src
            assign w_opa    = in_a;
            assign w_opb    = w_b0;
            assign w_vi     = in_valid;
            assign w_ci     = w_c0;
            assign w_sum_nx = w_res[SEG-1:0];
        end else begin : g_src
            assign w_opa    = g_stage[k-1].g_fwd.r_a;
            assign w_opb    = g_stage[k-1].g_fwd.r_b;
            assign w_vi     = g_stage[k-1].r_v;
            assign w_ci     = g_stage[k-1].r_c;
            assign w_sum_nx = {w_res[SEG-1:0], g_stage[k-1].r_sum};
        end

        assign w_res = f_seg(w_opa[SEG-1:0], w_opb[SEG-1:0], w_ci);

        // A stage may load when it is empty or its successor is moving.
        if (k == STAGES - 1) begin : g_adv
            assign w_adv = !r_v | out_ready;
        end else begin : g_adv
            assign w_adv = !r_v | g_stage[k+1].w_adv;
        end

        // Stage register: valid bit, segment carry and accumulated low sum.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_v   <= 1'b0;
                r_c   <= 1'b0;
                r_sum <= '0;
            end else if (w_adv) begin
                r_v <= w_vi;
                if (w_vi) begin
                    r_c   <= w_res[SEG];
                    r_sum <= w_sum_nx;
                end
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [OPW-SEG-1:0] r_a;
            logic [OPW-SEG-1:0] r_b;

            // Forward only the operand bits later stages still need.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv && w_vi) begin
                    r_a <= w_opa[OPW-1:SEG];
                    r_b <= w_opb[OPW-1:SEG];
                end
            end
        end
    end

    assign in_ready  = g_stage[0].w_adv;
    assign out_valid = g_stage[STAGES-1].r_v;
    assign out_sum   = g_stage[STAGES-1].r_sum;
    assign out_cout  = g_stage[STAGES-1].r_c;

endmodule
`default_nettype wire
